pool2d_stream: RTL

Parametrised 2×2, stride-2 pooling stage for a raster-ordered feature-map stream, with selectable max or average mode. It sits between a convolution stage and the next layer, and holds one image row in an internal line buffer, so no external FIFO is needed. It accepts one pixel per cycle with arbitrary gaps in `in_valid`, handles odd image dimensions, and supports back-to-back frames.

---
 rtl/pool2d_stream.sv | 94 +++++++++
 1 files changed

// File: rtl/pool2d_stream.sv
// 2x2 stride-2 max/average pooling over a raster-ordered pixel stream.
// One image row is held in an internal line buffer; odd trailing rows/columns are consumed but not pooled.
module pool2d_stream #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_avg,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LAST_COL = 2 * (IMG_W / 2) - 1;
    localparam int LAST_ROW = 2 * (IMG_H / 2) - 1;

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic                     r_mode;
    logic signed [DATA_W-1:0] r_left;
    logic signed [DATA_W-1:0] r_line_buf [IMG_W];

    logic                     w_col_end;
    logic                     w_row_end;
    logic                     w_win_done;
    logic                     w_win_last;
    logic [CW-1:0]            w_col_left;
    logic signed [DATA_W-1:0] w_p0, w_p1, w_p2, w_p3;
    logic signed [DATA_W-1:0] w_max01, w_max23, w_max;
    logic signed [DATA_W+1:0] w_sum;
    logic signed [DATA_W-1:0] w_avg;
    logic signed [DATA_W-1:0] w_result;

    assign w_col_end  = (r_col == CW'(IMG_W - 1));
    assign w_row_end  = (r_row == RW'(IMG_H - 1));
    // Odd row and odd column is always a bottom-right pixel; a trailing odd column/row is even-indexed.
    assign w_win_done = in_valid & r_row[0] & r_col[0];
    assign w_win_last = w_win_done && (r_row == RW'(LAST_ROW)) && (r_col == CW'(LAST_COL));
    assign w_col_left = r_col - CW'(1);

    assign w_p0 = r_line_buf[w_col_left];
    assign w_p1 = r_line_buf[r_col];
    assign w_p2 = r_left;
    assign w_p3 = $signed(in_data);

    assign w_max01 = (w_p0 > w_p1) ? w_p0 : w_p1;
    assign w_max23 = (w_p2 > w_p3) ? w_p2 : w_p3;
    assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;

    // Two guard bits keep the 4-way sum exact; >>> floors toward minus infinity.
    assign w_sum    = {{2{w_p0[DATA_W-1]}}, w_p0} + {{2{w_p1[DATA_W-1]}}, w_p1}
                    + {{2{w_p2[DATA_W-1]}}, w_p2} + {{2{w_p3[DATA_W-1]}}, w_p3};
    assign w_avg    = DATA_W'(w_sum >>> 2);
    assign w_result = r_mode ? w_avg : w_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_mode    <= 1'b0;
            r_left    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= w_win_done;
            out_data  <= w_win_done ? w_result : '0;
            out_last  <= w_win_last;
            if (in_valid) begin
                if ((r_row == '0) && (r_col == '0))
                    r_mode <= mode_avg;
                if (r_row[0] && !r_col[0])
                    r_left <= $signed(in_data);
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Contents need no reset: every entry is rewritten on an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        if (in_valid && !r_row[0])
            r_line_buf[r_col] <= $signed(in_data);
    end
endmodule
